// File: rtl/morse_key_timer_if.sv
// Key input and symbol/letter outputs of the Morse key timer.
// The timer side uses master; the downstream encoder/display side uses slave.
interface morse_key_timer_if;
  logic       key_in;
  logic       key_db;
  logic       sym_valid;
  logic       sym_dash;
  logic       letter_valid;
  logic [4:0] letter_bits;
  logic [2:0] letter_len;
  logic       letter_err;

  modport master (
    input  key_in,
    output key_db, sym_valid, sym_dash,
    output letter_valid, letter_bits, letter_len, letter_err
  );

  modport slave (
    output key_in,
    input  key_db, sym_valid, sym_dash,
    input  letter_valid, letter_bits, letter_len, letter_err
  );
endinterface

// File: rtl/morse_key_timer.sv
// Telegraph key front end: synchronize, debounce, time each press as dot/dash,
// and group symbols into letters separated by a silence gap.
module morse_key_timer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DASH_CYCLES     = 10000000,
  parameter int GAP_CYCLES      = 20000000,
  parameter int CNT_W           = 25
) (
  input  logic              clk,
  input  logic              resetn,
  morse_key_timer_if.master mk
);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_MAX = CNT_W'(DASH_CYCLES);
  localparam logic [CNT_W-1:0] GAP_MAX  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  logic             sync_p0, sync_p1;
  logic             key_sync;
  logic             key_db_p2;
  logic [CNT_W-1:0] db_cnt;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] press_cnt, press_cnt_nxt;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;
  logic             sym_fire, sym_is_dash, letter_fire;

  logic [4:0]       acc_bits;
  logic [2:0]       acc_len;
  logic             acc_err;

  logic             sym_vld_p3, sym_dash_p3;
  logic             letter_vld_p3, letter_err_p3;
  logic [4:0]       letter_bits_p3;
  logic [2:0]       letter_len_p3;

  assign key_sync = ~sync_p1;

  // Stages p0/p1: synchronizer; p2: debounced level (changes only after a stable run)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_p0   <= 1'b1;
      sync_p1   <= 1'b1;
      key_db_p2 <= 1'b0;
      db_cnt    <= '0;
    end else begin
      sync_p0 <= mk.key_in;
      sync_p1 <= sync_p0;
      if (key_sync == key_db_p2) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt    <= '0;
        key_db_p2 <= ~key_db_p2;
      end else begin
        db_cnt <= db_cnt + CNT_ONE;
      end
    end
  end

  // The release cycle that ends a press also counts as the first gap cycle.
  always_comb begin
    state_nxt     = state;
    press_cnt_nxt = press_cnt;
    gap_cnt_nxt   = gap_cnt;
    sym_fire      = 1'b0;
    sym_is_dash   = 1'b0;
    letter_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (key_db_p2) begin
          state_nxt     = PRESS;
          press_cnt_nxt = CNT_ONE;
        end
      end
      PRESS: begin
        if (key_db_p2) begin
          if (press_cnt < DASH_MAX) press_cnt_nxt = press_cnt + CNT_ONE;
        end else begin
          sym_fire    = 1'b1;
          sym_is_dash = (press_cnt >= DASH_MAX);
          state_nxt   = GAP;
          gap_cnt_nxt = CNT_ONE;
        end
      end
      GAP: begin
        if (gap_cnt >= GAP_MAX) begin
          letter_fire = 1'b1;
          state_nxt   = key_db_p2 ? PRESS : IDLE;
          if (key_db_p2) press_cnt_nxt = CNT_ONE;
        end else if (key_db_p2) begin
          state_nxt     = PRESS;
          press_cnt_nxt = CNT_ONE;
        end else begin
          gap_cnt_nxt = gap_cnt + CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p3: registered symbol/letter pulses, accumulator update
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      press_cnt      <= '0;
      gap_cnt        <= '0;
      acc_bits       <= '0;
      acc_len        <= '0;
      acc_err        <= 1'b0;
      sym_vld_p3     <= 1'b0;
      sym_dash_p3    <= 1'b0;
      letter_vld_p3  <= 1'b0;
      letter_bits_p3 <= '0;
      letter_len_p3  <= '0;
      letter_err_p3  <= 1'b0;
    end else begin
      state         <= state_nxt;
      press_cnt     <= press_cnt_nxt;
      gap_cnt       <= gap_cnt_nxt;
      sym_vld_p3    <= sym_fire;
      letter_vld_p3 <= letter_fire;
      if (sym_fire) begin
        sym_dash_p3 <= sym_is_dash;
        if (acc_len == 3'd5) begin
          acc_err <= 1'b1;
        end else begin
          acc_bits <= {acc_bits[3:0], sym_is_dash};
          acc_len  <= acc_len + 3'd1;
        end
      end
      if (letter_fire) begin
        letter_bits_p3 <= acc_bits;
        letter_len_p3  <= acc_len;
        letter_err_p3  <= acc_err;
        acc_bits       <= '0;
        acc_len        <= '0;
        acc_err        <= 1'b0;
      end
    end
  end

  assign mk.key_db       = key_db_p2;
  assign mk.sym_valid    = sym_vld_p3;
  assign mk.sym_dash     = sym_dash_p3;
  assign mk.letter_valid = letter_vld_p3;
  assign mk.letter_bits  = letter_bits_p3;
  assign mk.letter_len   = letter_len_p3;
  assign mk.letter_err   = letter_err_p3;
endmodule

// File: tb/tb_morse_key_timer.sv
// Directed bench for morse_key_timer: expected symbols/letters are queued as
// presses are driven and compared when the pulses appear.
module tb_morse_key_timer;
  localparam int DEB  = 4;
  localparam int DASH = 20;
  localparam int GAP  = 40;
  localparam int CW   = 8;

  typedef struct packed {
    logic [4:0] bits;
    logic [2:0] len;
    logic       err;
  } letter_t;

  logic    clk = 1'b0;
  logic    resetn;
  int      checks = 0;
  int      errors = 0;
  logic    sym_q[$];
  letter_t let_q[$];
  letter_t exp_l;

  morse_key_timer_if mk();

  morse_key_timer #(
    .DEBOUNCE_CYCLES(DEB),
    .DASH_CYCLES    (DASH),
    .GAP_CYCLES     (GAP),
    .CNT_W          (CW)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .mk    (mk)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int h, input logic dash);
    sym_q.push_back(dash);
    mk.key_in = 1'b0;
    repeat (h) @(negedge clk);
    mk.key_in = 1'b1;
  endtask

  task automatic expect_letter(input logic [4:0] b, input logic [2:0] l, input logic e);
    let_q.push_back({b, l, e});
  endtask

  task automatic drained(input string tag);
    check({tag, "_sym_pending"}, 32'(sym_q.size()), 32'd0);
    check({tag, "_letter_pending"}, 32'(let_q.size()), 32'd0);
  endtask

  // Scoreboard side: every pulse must match the head of its queue.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (mk.sym_valid === 1'b1 || mk.letter_valid === 1'b1)
        check("pulse_overlap", 32'(mk.sym_valid & mk.letter_valid), 32'd0);
      if (mk.sym_valid === 1'b1) begin
        if (sym_q.size() == 0) check("sym_unexpected", 32'(mk.sym_valid), 32'd0);
        else check("sym_dash", 32'(mk.sym_dash), 32'(sym_q.pop_front()));
      end
      if (mk.letter_valid === 1'b1) begin
        if (let_q.size() == 0) begin
          check("letter_unexpected", 32'(mk.letter_valid), 32'd0);
        end else begin
          exp_l = let_q.pop_front();
          check("letter_bits", 32'(mk.letter_bits), 32'(exp_l.bits));
          check("letter_len", 32'(mk.letter_len), 32'(exp_l.len));
          check("letter_err", 32'(mk.letter_err), 32'(exp_l.err));
        end
      end
    end
  end

  initial begin
    resetn    = 1'b0;
    mk.key_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_key_db", 32'(mk.key_db), 32'd0);
    check("rst_sym_valid", 32'(mk.sym_valid), 32'd0);
    check("rst_sym_dash", 32'(mk.sym_dash), 32'd0);
    check("rst_letter_valid", 32'(mk.letter_valid), 32'd0);
    check("rst_letter_bits", 32'(mk.letter_bits), 32'd0);
    check("rst_letter_len", 32'(mk.letter_len), 32'd0);
    check("rst_letter_err", 32'(mk.letter_err), 32'd0);

    // Key held through reset release: rises after 2 sync + 4 debounce cycles.
    resetn = 1'b1;
    sym_q.push_back(1'b0);
    repeat (5) @(negedge clk);
    check("db_rise_early", 32'(mk.key_db), 32'd0);
    @(negedge clk);
    check("db_rise", 32'(mk.key_db), 32'd1);
    repeat (4) @(negedge clk);
    mk.key_in = 1'b1;
    expect_letter(5'b00000, 3'd1, 1'b0);
    idle(60);
    drained("reset_press");

    // Bounce shorter than the debounce window.
    for (int r = 0; r < 5; r++) begin
      mk.key_in = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("bounce_db_low", 32'(mk.key_db), 32'd0);
      end
      mk.key_in = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("bounce_db_high", 32'(mk.key_db), 32'd0);
      end
    end
    idle(10);
    check("bounce_db_end", 32'(mk.key_db), 32'd0);
    drained("bounce");

    // Letter A: dot, dash.
    press(10, 1'b0);
    idle(10);
    press(30, 1'b1);
    expect_letter(5'b00001, 3'd2, 1'b0);
    idle(50);
    drained("letter_a");
    check("hold_letter_bits", 32'(mk.letter_bits), 32'd1);
    check("hold_letter_len", 32'(mk.letter_len), 32'd2);
    check("hold_sym_dash", 32'(mk.sym_dash), 32'd1);

    // Dash threshold and gap threshold (39 keeps letter open, 40 closes it).
    press(19, 1'b0);
    idle(39);
    press(20, 1'b1);
    expect_letter(5'b00001, 3'd2, 1'b0);
    idle(40);
    press(5, 1'b0);
    expect_letter(5'b00000, 3'd1, 1'b0);
    idle(60);
    drained("threshold");

    // Overflow: six dots in one letter, then a fresh single dash.
    for (int i = 0; i < 6; i++) begin
      press(5, 1'b0);
      if (i < 5) idle(10);
    end
    expect_letter(5'b00000, 3'd5, 1'b1);
    idle(60);
    drained("overflow");
    press(25, 1'b1);
    expect_letter(5'b00001, 3'd1, 1'b0);
    idle(60);
    drained("after_overflow");

    // Reset during the gap discards the open letter.
    press(25, 1'b1);
    idle(20);
    check("mid_sym_seen", 32'(sym_q.size()), 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    idle(60);
    check("mid_letter_bits", 32'(mk.letter_bits), 32'd0);
    check("mid_letter_len", 32'(mk.letter_len), 32'd0);
    check("mid_letter_err", 32'(mk.letter_err), 32'd0);
    check("mid_key_db", 32'(mk.key_db), 32'd0);
    drained("mid_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/morse_key_timer.md
Name: morse_key_timer

Overview:
- Front end of the Morse path. Takes a single raw telegraph pushbutton, synchronizes and debounces it, and classifies each press as a dot or a dash by how long it is held.
- Groups symbols into letters by detecting an inter-letter silence gap.
- Emits per-symbol pulses and a per-letter code/length word for the downstream encoder/display stage, which replaces its separate dot/dash buttons.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before the debounced level changes (1 ms at 50 MHz).
- DASH_CYCLES, 10000000: a press held at least this many cycles is a dash; shorter presses are dots (200 ms).
- GAP_CYCLES, 20000000: released cycles after the last symbol that close the current letter (400 ms).
- CNT_W, 25: width of the internal counters. Must hold max(DEBOUNCE_CYCLES, DASH_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- key_in  input  1  raw pushbutton, asynchronous, active-low (0 = pressed).
- key_db  output  1  debounced key level, 1 = pressed.
- sym_valid  output  1  one-cycle pulse: a symbol completed.
- sym_dash  output  1  qualifies sym_valid: 1 = dash, 0 = dot.
- letter_valid  output  1  one-cycle pulse: a letter closed.
- letter_bits  output  5  letter code. Most recent symbol in bit 0, dash = 1, dot = 0; bits at or above letter_len are 0.
- letter_len  output  3  number of symbols in the letter, 1..5.
- letter_err  output  1  letter exceeded 5 symbols; qualified by letter_valid.

Behaviour:
- Reset (resetn = 0 at a clock edge):
  - Synchronizer flops are loaded with the released level (1).
  - key_db = 0; all counters = 0; FSM = IDLE.
  - sym_valid, sym_dash, letter_valid, letter_err = 0; letter_bits = 0; letter_len = 0.
- Synchronizer: two flops on key_in, inverted to active-high.
- Debounce:
  - A counter runs while the synchronized level differs from key_db, and clears whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, key_db toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change key_db.
- Hold duration H is the number of cycles key_db = 1, so the debounce delay cancels out.
- FSM states are IDLE, PRESS and GAP:
  - IDLE: accumulator empty. key_db = 1 → PRESS, press counter = 1.
  - PRESS: the press counter increments each cycle key_db = 1 and saturates at DASH_CYCLES.
    - On the first cycle key_db = 0, the symbol is decided: dash iff H ≥ DASH_CYCLES.
    - Next cycle: sym_valid = 1 and sym_dash holds the decision.
    - In that same cycle the symbol is appended to the accumulator (shift left, insert at bit 0, length + 1).
    - FSM → GAP with the gap counter = 1.
  - GAP: the gap counter increments each cycle key_db = 0.
    - key_db = 1 → PRESS (press counter = 1, gap discarded).
    - Gap counter reaching GAP_CYCLES: next cycle letter_valid = 1, with letter_bits, letter_len and letter_err presented from the accumulator.
    - In that same cycle the accumulator and error flag clear and FSM → IDLE.
- Output holding:
  - letter_bits, letter_len and letter_err hold their values until the next letter_valid.
  - sym_dash holds until the next sym_valid.
- Overflow: a 6th or later symbol in one letter is not shifted in. letter_len stays 5, letter_bits keeps its first 5 symbols, and the internal error flag is set. sym_valid still pulses for every symbol.
- Simultaneous events: if key_db rises on the same cycle the gap counter reaches GAP_CYCLES, the letter is emitted first and the press starts a new letter (FSM → PRESS).
- sym_valid and letter_valid are never high in the same cycle. The minimum spacing is guaranteed by GAP_CYCLES ≥ 2.
- Reset mid-press or mid-letter: the partial symbol and letter are discarded with no pulses. If the key is still held after reset, it is re-debounced from the released state and timed as a new press.
- There is no letter with 0 symbols; letter_valid only follows at least one symbol.

Test Plan:
(Simulation parameters: DEBOUNCE_CYCLES = 4, DASH_CYCLES = 20, GAP_CYCLES = 40, CNT_W = 8.)
- Reset: hold resetn = 0 for 3 cycles with key_in = 0 → all outputs 0. Release reset with the key held → key_db = 1 after 2 + 4 cycles.
- Bounce: key_in low for 3 cycles, then high, repeated 5 times → key_db stays 0; no sym_valid, no letter_valid.
- Letter A: press H = 10, release 10, press H = 30, release 50 → sym_valid with sym_dash 0, then sym_valid with sym_dash 1. Then letter_valid with letter_bits = 00001, letter_len = 2, letter_err = 0.
- Threshold: H = 19 → sym_dash = 0; H = 20 → sym_dash = 1. Gap of 39 cycles then a press → no letter_valid; gap of 40 → letter_valid exactly once.
- Overflow: six dots (H = 5, gaps of 10), then silence → six sym_valid pulses; letter_valid with letter_bits = 00000, letter_len = 5, letter_err = 1. The next single dash gives letter_bits = 00001, letter_len = 1, letter_err = 0.
- Reset mid-letter: one dash, then resetn pulsed during the gap → no letter_valid; letter outputs read 0 afterwards.
